// File: rtl/rmii_frame_tx_pkg.sv
// Shared Ethernet framing constants, FSM states and the dibit CRC-32 step
// for the RMII transmit path.
package rmii_frame_tx_pkg;

  localparam int unsigned ETH_PREAMBLE_LEN = 7;
  localparam int unsigned ETH_HEADER_LEN   = 14;
  localparam int unsigned ETH_MIN_PAYLOAD  = 46;
  localparam int unsigned ETH_FCS_LEN      = 4;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE    = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_HEADER, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
  } eth_hdr_t;

  // Reflected CRC-32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc32_dibit_step(input logic [31:0] crc,
                                                   input logic [1:0]  dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c[0] ^ dibit[i]) ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rmii_frame_tx_crc32_dibit.sv
// Dibit-serial CRC-32 register; also used by the receive-side FCS checker.
module crc32_dibit
  import rmii_frame_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC32_INIT;
    end else if (en) begin
      crc_d = crc32_dibit_step(crc_q, dibit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC32_INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/rmii_frame_tx.sv
// RMII frame transmitter: preamble, SFD, header, streamed payload, pad, FCS
// and inter-frame gap, one dibit per 50 MHz cycle.
module rmii_frame_tx
  import rmii_frame_tx_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned IFG_CYCLES  = 48,
  parameter int unsigned LEN_WIDTH   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [47:0]          dst_mac,
  input  logic [47:0]          src_mac,
  input  logic [15:0]          ethertype,
  input  logic [LEN_WIDTH-1:0] payload_len,
  output logic                 readclk,
  input  logic                 inclk,
  input  logic [7:0]           in,
  output logic                 txen,
  output logic [1:0]           txd,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [1:0]           dib_q, dib_d;
  eth_hdr_t             hdr_q, hdr_d;
  logic [7:0]           buf_q, buf_d, pay_q, pay_d;
  logic                 buf_vld_q, buf_vld_d, pend_q, pend_d;
  logic                 txen_q, txen_d, readclk_q, readclk_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]           txd_q, txd_d;

  logic [LEN_WIDTH-1:0] pad_c, seg_len_c, hdr_idx_c;
  state_t               seg_nxt_c;
  logic [111:0]         hdr_bits_c;
  logic [7:0]           tx_byte_c;
  logic                 under_c, crc_clear_c, crc_en_c;
  logic [31:0]          crc_w;

  assign pad_c      = (len_q < LEN_WIDTH'(MIN_PAYLOAD)) ? LEN_WIDTH'(MIN_PAYLOAD) - len_q : '0;
  assign hdr_bits_c = hdr_q;

  // Length of the current segment in bytes and the segment that follows it.
  always_comb begin
    seg_len_c = LEN_WIDTH'(1);
    seg_nxt_c = S_IDLE;
    case (state_q)
      S_PREAMBLE: begin seg_len_c = LEN_WIDTH'(ETH_PREAMBLE_LEN); seg_nxt_c = S_SFD; end
      S_SFD:      begin seg_len_c = LEN_WIDTH'(1);                seg_nxt_c = S_HEADER; end
      S_HEADER:   begin
        seg_len_c = LEN_WIDTH'(ETH_HEADER_LEN);
        seg_nxt_c = (len_q != '0) ? S_PAYLOAD : S_PAD;
      end
      S_PAYLOAD:  begin seg_len_c = len_q; seg_nxt_c = (pad_c != '0) ? S_PAD : S_FCS; end
      S_PAD:      begin seg_len_c = pad_c; seg_nxt_c = S_FCS; end
      S_FCS:      begin seg_len_c = LEN_WIDTH'(ETH_FCS_LEN); seg_nxt_c = S_IFG; end
      default:    ;
    endcase
  end

  // Registers describe the dibit on the wire; this block picks the next one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dib_d       = dib_q;
    hdr_d       = hdr_q;
    len_d       = len_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    pend_d      = pend_q;
    pay_d       = pay_q;
    txen_d      = 1'b0;
    txd_d       = 2'b00;
    readclk_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    tx_byte_c   = 8'h00;
    under_c     = 1'b0;
    hdr_idx_c   = '0;
    crc_clear_c = 1'b0;
    crc_en_c    = 1'b0;

    if (inclk && pend_q) begin
      buf_d     = in;
      buf_vld_d = 1'b1;
      pend_d    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (payload_len > LEN_WIDTH'(MAX_PAYLOAD)) begin
            err_d = 1'b1;
          end else begin
            state_d   = S_PREAMBLE;
            cnt_d     = '0;
            dib_d     = 2'd0;
            hdr_d     = '{dst: dst_mac, src: src_mac, ethertype: ethertype};
            len_d     = payload_len;
            buf_vld_d = 1'b0;
            pend_d    = 1'b0;
          end
        end
      end
      S_IFG: begin
        if (cnt_q == LEN_WIDTH'(IFG_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
      end
      default: begin
        dib_d = dib_q + 2'd1;
        if (dib_q == 2'd3) begin
          if (cnt_q + LEN_WIDTH'(1) == seg_len_c) begin
            state_d = seg_nxt_c;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
      end
    endcase

    hdr_idx_c = LEN_WIDTH'(ETH_HEADER_LEN - 1) - cnt_d;
    case (state_d)
      S_PREAMBLE: tx_byte_c = ETH_PREAMBLE_BYTE;
      S_SFD:      tx_byte_c = ETH_SFD_BYTE;
      S_HEADER:   tx_byte_c = 8'(hdr_bits_c >> {hdr_idx_c, 3'b000});
      S_PAYLOAD: begin
        if (dib_d != 2'd0) begin
          tx_byte_c = pay_q;
        end else if (buf_vld_q || (pend_q && inclk)) begin
          // A byte arriving in the very cycle it is needed is forwarded.
          tx_byte_c = buf_vld_q ? buf_q : in;
          pay_d     = tx_byte_c;
          buf_vld_d = 1'b0;
          readclk_d = (cnt_d + LEN_WIDTH'(1)) < len_q;
        end else begin
          under_c = 1'b1;
        end
      end
      S_FCS:      tx_byte_c = 8'(~crc_w >> {cnt_d[1:0], 3'b000});
      default:    tx_byte_c = 8'h00;
    endcase

    if (under_c) begin
      state_d = S_IFG;
      cnt_d   = '0;
      dib_d   = 2'd0;
      err_d   = 1'b1;
    end else if (state_d inside {S_PREAMBLE, S_SFD, S_HEADER, S_PAYLOAD, S_PAD, S_FCS}) begin
      txen_d = 1'b1;
      txd_d  = 2'(tx_byte_c >> {dib_d, 1'b0});
    end

    if (state_d == S_HEADER && cnt_d == LEN_WIDTH'(ETH_HEADER_LEN - 1) &&
        dib_d == 2'd0 && len_q != '0) begin
      readclk_d = 1'b1;
    end
    if (readclk_d) pend_d = 1'b1;

    done_d      = (state_q == S_FCS) && (state_d == S_IFG);
    crc_clear_c = (state_d == S_SFD);
    crc_en_c    = txen_d && (state_d inside {S_HEADER, S_PAYLOAD, S_PAD});
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dib_q     <= 2'd0;
      hdr_q     <= '0;
      len_q     <= '0;
      buf_q     <= 8'h00;
      buf_vld_q <= 1'b0;
      pend_q    <= 1'b0;
      pay_q     <= 8'h00;
      txen_q    <= 1'b0;
      txd_q     <= 2'b00;
      readclk_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dib_q     <= dib_d;
      hdr_q     <= hdr_d;
      len_q     <= len_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      pend_q    <= pend_d;
      pay_q     <= pay_d;
      txen_q    <= txen_d;
      txd_q     <= txd_d;
      readclk_q <= readclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  crc32_dibit u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (crc_clear_c),
    .en    (crc_en_c),
    .dibit (txd_d),
    .crc   (crc_w)
  );

  assign txen    = txen_q;
  assign txd     = txd_q;
  assign readclk = readclk_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
